// File: rtl/lcd_ctrl_if.sv
// lcd_ctrl_if: LSU write request, LCD pin bundle and status flags of the LCD controller.
// slave = controller side, master = requester/observer side.
interface lcd_ctrl_if;
    logic        lcd_valid_i;
    logic [31:0] lcd_word_i;
    logic        lcd_on_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic        lcd_en_o;
    logic [7:0]  lcd_data_o;
    logic        busy_o;
    logic        done_o;
    logic        overflow_o;
    modport slave (
        input  lcd_valid_i, lcd_word_i,
        output lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o, busy_o, done_o, overflow_o
    );
    modport master (
        output lcd_valid_i, lcd_word_i,
        input  lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o, busy_o, done_o, overflow_o
    );
endinterface

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns one-cycle LSU stores into timed HD44780 write cycles with a one-deep request buffer.
// Define LCD_CLR_LONG_EN to wait T_CLEAR after clear/home commands instead of T_EXEC.
module lcd_ctrl #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 25,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 2000,
    parameter int unsigned T_CLEAR = 82000,
    parameter int unsigned CNT_W   = 17
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    lcd_ctrl_if.slave   bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] PULSE = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);

    // request packing: [9] on, [8] rs, [7:0] data
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, ld_wait;
    logic [9:0]       act_q, act_d, pend_q, pend_d, req;
    logic             pend_v_q, pend_v_d, ovf_q, ovf_d, en_q, en_d, last, unused_bits;

    assign req = {bus.lcd_word_i[31], bus.lcd_word_i[9], bus.lcd_word_i[7:0]};
    assign unused_bits = ^{bus.lcd_word_i[30:10], bus.lcd_word_i[8], T_CLEAR};
    assign last = (state_q == WAIT) && (timer_q == '0);
`ifdef LCD_CLR_LONG_EN
    assign ld_wait = (!act_q[8] && act_q[7:2] == '0 && act_q[1:0] != '0) ? CNT_W'(T_CLEAR - 1) : LD_EXEC;
`else
    assign ld_wait = LD_EXEC;
`endif

    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q == '0) ? '0 : timer_q - CNT_W'(1);
        act_d    = act_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ovf_d    = ovf_q;
        if (state_q == IDLE) begin
            if (bus.lcd_valid_i) begin
                act_d   = req;
                state_d = SETUP;
                timer_d = LD_SETUP;
            end
        end else if (timer_q == '0) begin
            case (state_q)
                SETUP:   begin state_d = PULSE; timer_d = LD_PULSE; end
                PULSE:   begin state_d = HOLD;  timer_d = LD_HOLD;  end
                HOLD:    begin state_d = WAIT;  timer_d = ld_wait;  end
                default: begin
                    // chain straight into the next request so busy never drops between transfers
                    state_d = (pend_v_q || bus.lcd_valid_i) ? SETUP : IDLE;
                    timer_d = (pend_v_q || bus.lcd_valid_i) ? LD_SETUP : '0;
                    act_d   = pend_v_q ? pend_q : (bus.lcd_valid_i ? req : act_q);
                end
            endcase
        end
        if (state_q != IDLE && bus.lcd_valid_i) begin
            if (!pend_v_q && !last) begin
                pend_d   = req;
                pend_v_d = 1'b1;
            end else if (pend_v_q && last) begin
                pend_d = req;
            end else if (pend_v_q) begin
                ovf_d = 1'b1;
            end
        end else if (last) begin
            pend_v_d = 1'b0;
        end
        en_d = (state_d == PULSE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            act_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            ovf_q    <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            ovf_q    <= ovf_d;
            en_q     <= en_d;
        end
    end

    assign bus.lcd_on_o   = act_q[9];
    assign bus.lcd_rs_o   = act_q[8];
    assign bus.lcd_data_o = act_q[7:0];
    assign bus.lcd_rw_o   = 1'b0;
    assign bus.lcd_en_o   = en_q;
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.done_o     = last;
    assign bus.overflow_o = ovf_q;
endmodule
